// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 7-segment display scanner.
//
// A prescaler divides the clock into digit slots. Each slot selects the next digit.
// A frame is one pass over all digits. The digit/dp inputs are captured at each frame
// boundary, so the display never tears mid-frame. A 4-bit PWM counter gates the
// outputs for brightness control. Optional leading-zero blanking is applied to the
// captured digits.
//
// Parameters:
//   DIGITS         number of multiplexed digits (1..16)
//   PRESCALE       clocks per digit slot (multiple of 16, >= 16)
//   SEG_ACTIVE_LOW invert every seg bit at the output
//   SEL_ACTIVE_LOW invert every seg_sel bit at the output
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   digits      hex nibbles, digit k at [4k+3:4k]
//   dp          decimal-point request per digit
//   blank_lz    enable leading-zero blanking
//   brightness  PWM duty code, lit while pwm <= brightness
//   seg         registered segments, bit7 = dp, bits6..0 = g..a
//   seg_sel     registered one-hot digit enable
//   frame_tick  one-cycle pulse at the start of each new frame
module seg_scan_controller #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned PRESCALE       = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     seg_sel,
  output logic                  frame_tick
);

  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PcntW = $clog2(PRESCALE);

  localparam logic [PcntW-1:0]  PcntMax = PcntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0]   IdxMax  = IdxW'(DIGITS - 1);
  localparam logic [7:0]        SegInv  = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SelInv  = {DIGITS{SEL_ACTIVE_LOW}};

  // Segment font, bits 6..0 = g..a.
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [PcntW-1:0]    pcnt_q, pcnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [4*DIGITS-1:0] snap_digits_q;
  logic [DIGITS-1:0]   snap_dp_q;
  logic                frame_tick_q;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   seg_sel_q;

  logic                slot_end;
  logic                frame_end;
  logic                lit;
  logic                upper_zero;
  logic                blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [DIGITS-1:0]   sel_onehot;
  logic [7:0]          seg_raw;
  logic [DIGITS-1:0]   sel_raw;

  assign slot_end  = (pcnt_q == PcntMax);
  assign frame_end = slot_end && (idx_q == IdxMax);

  // Counter next-state.
  always_comb begin
    pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
    pwm_d  = pwm_q + 4'd1;
    idx_d  = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit from the snapshot, and find whether it and every
  // higher digit are zero (the leading-zero condition).
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    sel_onehot = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib       = snap_digits_q[4*k +: 4];
        cur_dp        = snap_dp_q[k];
        sel_onehot[k] = 1'b1;
      end
      if ((IdxW'(k) >= idx_q) && (snap_digits_q[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never blanked; a blanked digit still shows its dp.
  assign blank   = blank_lz && (idx_q != '0) && upper_zero;
  assign lit     = (pwm_q <= brightness);
  assign seg_raw = lit ? {cur_dp, (blank ? 7'h00 : font(cur_nib))} : 8'h00;
  assign sel_raw = lit ? sel_onehot : '0;

  // Polarity is folded in before the output registers so that the reset values
  // are inverted too.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      frame_tick_q  <= 1'b0;
      seg_q         <= SegInv;
      seg_sel_q     <= SelInv;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_end;
      if (frame_end) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp;
      end
      seg_q     <= seg_raw ^ SegInv;
      seg_sel_q <= sel_raw ^ SelInv;
    end
  end

  assign seg        = seg_q;
  assign seg_sel    = seg_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: self-checking bench for seg_scan_controller.
//
// Two instances share all inputs: dut_a (PRESCALE=16, active-high outputs) and
// dut_b (PRESCALE=32, active-low seg and seg_sel). A behavioural model derives
// every output from the number of edges since reset, using plain arithmetic.
module tb_seg_scan_controller;

  localparam int D = 6;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          reset;
  logic [4*D-1:0] digits;
  logic [D-1:0]  dp;
  logic          blank_lz;
  logic [3:0]    brightness;

  logic [7:0]    seg_a, seg_b;
  logic [D-1:0]  sel_a, sel_b;
  logic          tick_a, tick_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: edges since reset release, captured snapshot.
  int          t_a, t_b;
  logic [23:0] sd_a, sd_b;
  logic [5:0]  sdp_a, sdp_b;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .DIGITS(D), .PRESCALE(16), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .digits(digits), .dp(dp), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg_a), .seg_sel(sel_a), .frame_tick(tick_a)
  );

  seg_scan_controller #(
    .DIGITS(D), .PRESCALE(32), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .digits(digits), .dp(dp), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg_b), .seg_sel(sel_b), .frame_tick(tick_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after the edge just taken, from the inputs seen at that edge.
  task automatic model_step(input int p, input bit seg_inv, input bit sel_inv,
                            inout int t, inout logic [23:0] sd, inout logic [5:0] sdp,
                            output logic [7:0] es, output logic [5:0] esel, output logic et);
    int          idx;
    logic [23:0] upper;
    logic [7:0]  sv;
    logic [5:0]  lv;
    if (reset) begin
      t = 0; sd = '0; sdp = '0; sv = '0; lv = '0; et = 1'b0;
    end else begin
      idx   = (t / p) % D;
      upper = sd >> (4 * idx);
      sv[6:0] = (blank_lz && idx > 0 && upper == 24'h0) ? 7'h00 : FONT[upper[3:0]];
      sv[7]   = sdp[idx];
      lv      = 6'(1 << idx);
      if ((t % 16) > int'(brightness)) begin
        sv = '0;
        lv = '0;
      end
      et = ((t % (p * D)) == p * D - 1);
      if (et) begin
        sd  = digits;
        sdp = dp;
      end
      t++;
    end
    es   = seg_inv ? ~sv : sv;
    esel = sel_inv ? ~lv : lv;
  endtask

  task automatic step();
    logic [7:0] es;
    logic [5:0] esel;
    logic       et;
    @(posedge clk);
    #1;
    model_step(16, 1'b0, 1'b0, t_a, sd_a, sdp_a, es, esel, et);
    check_val("a_seg", 32'(seg_a), 32'(es));
    check_val("a_sel", 32'(sel_a), 32'(esel));
    check_val("a_tick", 32'(tick_a), 32'(et));
    model_step(32, 1'b1, 1'b1, t_b, sd_b, sdp_b, es, esel, et);
    check_val("b_seg", 32'(seg_b), 32'(es));
    check_val("b_sel", 32'(sel_b), 32'(esel));
    check_val("b_tick", 32'(tick_b), 32'(et));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int          cnt;
  int          nz;
  int          len;

  initial begin
    reset = 1'b1; digits = 24'h123456; dp = '0; blank_lz = 1'b0; brightness = 4'd15;
    t_a = 0; t_b = 0; sd_a = '0; sd_b = '0; sdp_a = '0; sdp_b = '0;

    // Reset state, both polarities.
    steps(3);
    check_val("rst_seg_a", 32'(seg_a), 32'h00);
    check_val("rst_sel_a", 32'(sel_a), 32'h00);
    check_val("rst_tick_a", 32'(tick_a), 32'h0);
    check_val("rst_seg_b", 32'(seg_b), 32'hFF);
    check_val("rst_sel_b", 32'(sel_b), 32'h3F);

    // First frame shows the zero snapshot; the wrap captures 0x123456.
    reset = 1'b0;
    step();
    check_val("first_sel_a", 32'(sel_a), 32'h01);
    check_val("first_seg_a", 32'(seg_a), 32'h3F);
    steps(94);
    check_val("pre_wrap_tick", 32'(tick_a), 32'h0);
    step();
    check_val("wrap_tick", 32'(tick_a), 32'h1);
    step();
    check_val("new_frame_seg", 32'(seg_a), 32'h7D);
    check_val("tick_one_cycle", 32'(tick_a), 32'h0);
    steps(40);
    digits = 24'hABCDEF; dp = 6'b101010;
    steps(300);

    // Leading-zero blanking: 0x000120 with dp on digit 2.
    reset = 1'b1; step();
    reset = 1'b0; digits = 24'h000120; dp = 6'b000100; blank_lz = 1'b1;
    steps(97);
    check_val("lz_d0", 32'(seg_a), 32'h3F);
    steps(16);
    check_val("lz_d1", 32'(seg_a), 32'h5B);
    steps(16);
    check_val("lz_d2", 32'(seg_a), 32'h86);
    steps(16);
    check_val("lz_d3", 32'(seg_a), 32'h00);
    check_val("lz_d3_sel", 32'(sel_a), 32'h08);
    digits = 24'h0; dp = '0;
    steps(250);

    // Brightness duty on dut_b: any 32 consecutive cycles span two pwm periods.
    brightness = 4'd3; step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (sel_b != 6'h3F) cnt++;
    end
    check_val("b_lit_bri3", 32'(cnt), 32'd8);
    brightness = 4'd0; step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (sel_b != 6'h3F) cnt++;
    end
    check_val("b_lit_bri0", 32'(cnt), 32'd2);

    // Mid-frame reset while dut_a is on digit 3.
    brightness = 4'd15; blank_lz = 1'b0; digits = 24'h987654;
    reset = 1'b1; step();
    reset = 1'b0;
    steps(50);
    reset = 1'b1; step();
    check_val("midrst_sel", 32'(sel_a), 32'h00);
    reset = 1'b0; step();
    check_val("midrst_restart_sel", 32'(sel_a), 32'h01);
    check_val("midrst_zero_snap", 32'(seg_a), 32'h3F);
    steps(200);

    // Randomized traffic with occasional resets and mid-frame input changes.
    for (int it = 0; it < 30; it++) begin
      nz         = $urandom_range(0, 6);
      digits     = 24'($urandom) >> (4 * nz);
      dp         = 6'($urandom);
      blank_lz   = 1'($urandom_range(0, 1));
      brightness = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        steps($urandom_range(1, 2));
        reset = 1'b0;
      end
      len = $urandom_range(20, 400);
      steps(len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter PRESCALE, default 1024: clocks per digit slot, a multiple of 16 and at least 16.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0: when 1, every seg bit is inverted at the output.
REQ-004 SHALL have parameter SEL_ACTIVE_LOW, default 0: when 1, every seg_sel bit is inverted at the output.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 digits  in  4*DIGITS  hex nibbles; digit k is bits [4k+3:4k]; digit 0 is least significant.
REQ-008 dp  in  DIGITS  decimal-point request per digit.
REQ-009 blank_lz  in  1  enables leading-zero blanking.
REQ-010 brightness  in  4  PWM duty code.
REQ-011 seg  out  8  registered segment pattern; bit7 = dp, bits6..0 = g..a.
REQ-012 seg_sel  out  DIGITS  registered one-hot digit enable.
REQ-013 frame_tick  out  1  one-cycle pulse marking the start of a new frame.

Function
REQ-014 SHALL count a prescaler pcnt from 0 to PRESCALE-1 and wrap; slot_end is defined as pcnt==PRESCALE-1.
REQ-015 SHALL advance the digit index idx by 1 on each slot_end, wrapping from DIGITS-1 to 0; idx width is max(1,clog2(DIGITS)).
REQ-016 On the edge where idx wraps to 0, SHALL load snapshot registers from digits and dp; the inputs SHALL NOT affect the display at any other time.
REQ-017 frame_tick SHALL be 1 for exactly the cycle following the wrap edge, and 0 otherwise.
REQ-018 SHALL run a 4-bit free-running counter pwm; the display is lit while pwm <= brightness (duty (brightness+1)/16; 15 = always lit).
REQ-019 Each edge SHALL register seg and seg_sel from the pre-edge idx, pwm and snapshot values; latency is 1 clock.
REQ-020 When lit, seg_sel SHALL be one-hot at bit idx; when unlit, seg_sel SHALL be all inactive and seg SHALL be all off.
REQ-021 Font for seg bits 6..0 SHALL be: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
REQ-022 With blank_lz=1, digit k>0 SHALL be blanked when it and all higher snapshot digits are 0; digit 0 is never blanked.
REQ-023 A blanked digit SHALL drive seg bits 6..0 off but still show its snapshot dp bit; seg_sel stays active.
REQ-024 blank_lz and brightness SHALL take effect combinationally into the next output register; they are not snapshotted.
REQ-025 Polarity inversion SHALL apply after all logic, including to the reset values.

Reset
REQ-026 While reset=1, the block SHALL set pcnt=0, idx=0, pwm=0, snapshot digits and dp to 0, frame_tick=0, and seg and seg_sel to inactive (0x00/0 before inversion).
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, scanning restarts at digit 0 showing the zero snapshot.

Verification
REQ-028 Reset and first frame: DIGITS=6, PRESCALE=16, brightness=15, blank_lz=0; hold reset 3 cycles -> seg=00, seg_sel=000000, frame_tick=0; one cycle after release -> seg_sel=000001, seg=3F.
REQ-029 Snapshot and scan: apply digits=0x123456 after reset -> first 96 cycles show zeros, stepping seg_sel every 16 cycles; then frame_tick pulses once, digit 0 shows 7D; changing digits mid-frame does not change the display until the next wrap.
REQ-030 Leading-zero blanking: digits=0x000120, dp=000100, blank_lz=1 -> digits 5..3 show 00, digit 2 shows 86, digit 1 shows 5B, digit 0 shows 3F; all-zero input -> only digit 0 shows 3F.
REQ-031 Brightness: PRESCALE=32, brightness=3 -> in each slot seg_sel is active on exactly 8 of 32 cycles (pwm 0..3 twice); brightness=0 -> 2 of 32.
REQ-032 Polarity: SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=1 -> during reset, seg=FF and seg_sel all ones; digit 8 lit -> seg=80, with the selected seg_sel bit at 0.
REQ-033 Mid-frame reset: assert reset for 1 cycle while idx=3 -> the next output has seg_sel inactive; after release, idx=0, the zero snapshot is shown, and frame_tick does not pulse until a full frame completes.
